shift_rotate_sequencer: RTL and testbench

//  Multi-cycle controller for the CPU shift/rotate unit. Captures Ra, Rb and an op code on start.

---
 rtl/shift_pkg.sv | 24 ++
 rtl/shift_step.sv | 27 ++
 rtl/shift_rotate_sequencer.sv | 105 ++++++++++
 tb/tb_shift_rotate_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate sequencer: op codes, FSM states, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

  // Default datapath widths; the amount field is log2 of the data width.
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 5;

  // Op code type and encodings; 101..111 are reserved and leave the operand untouched.
  typedef logic [2:0] op_t;

  localparam op_t OP_SHL  = 3'b000;
  localparam op_t OP_SHR  = 3'b001;
  localparam op_t OP_SHRA = 3'b010;
  localparam op_t OP_ROL  = 3'b011;
  localparam op_t OP_ROR  = 3'b100;

  // Sequencer FSM states.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step: a_next is a moved by one position according to op.
// Latency: purely combinational.
// Backpressure: none; reserved op codes pass the operand through unchanged.
module shift_step
  import shift_pkg::*;
#(
  parameter int W = DEF_DATA_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [2:0]   op,
  output logic [W-1:0] a_next
);

  // Select the single-position move; default keeps reserved codes a no-op.
  always_comb begin
    a_next = a;
    case (op)
      OP_SHL:  a_next = {a[W-2:0], 1'b0};
      OP_SHR:  a_next = {1'b0, a[W-1:1]};
      OP_SHRA: a_next = {a[W-1], a[W-1:1]};
      OP_ROL:  a_next = {a[W-2:0], a[W-1]};
      OP_ROR:  a_next = {a[0], a[W-1:1]};
      default: a_next = a;
    endcase
  end

endmodule

// File: rtl/shift_rotate_sequencer.sv
// Multi-cycle shift/rotate: one bit per clock until the captured amount is used up, result on Rz.
// Latency: start-to-done N+1 cycles (N = Rb[CNT_WIDTH-1:0]); one op every N+3 cycles back to back.
// Backpressure: start is honoured only in IDLE; starts while busy or in DONE are dropped, not queued.
module shift_rotate_sequencer
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] Ra,
  input  logic [DATA_WIDTH-1:0] Rb,
  output logic [DATA_WIDTH-1:0] Rz,
  output logic                  busy,
  output logic                  done
);

  logic [1:0]            state;
  logic [CNT_WIDTH-1:0]  count;
  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_next;
  logic                  accept;
  logic                  step_en;
  logic                  finish;

  // Upper amount bits wrap the amount modulo the data width, so they are deliberately dropped.
  logic unused_rb_hi;
  assign unused_rb_hi = ^Rb[DATA_WIDTH-1:CNT_WIDTH];

  // Decode the three events the registers care about from the current state.
  assign accept  = (state == IDLE) && start;
  assign step_en = (state == RUN) && (count != '0);
  assign finish  = (state == RUN) && (count == '0);

  shift_step #(
    .W (DATA_WIDTH)
  ) u_step (
    .a      (acc),
    .op     (op_q),
    .a_next (acc_next)
  );

  // Control FSM with busy/done flags; reset abandons any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (count == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Operand capture, per-cycle step and down-counter; inputs are ignored outside the accept cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc   <= '0;
      count <= '0;
      op_q  <= '0;
    end else if (accept) begin
      acc   <= Ra;
      count <= Rb[CNT_WIDTH-1:0];
      op_q  <= op;
    end else if (step_en) begin
      acc   <= acc_next;
      count <= count - CNT_WIDTH'(1);
    end
  end

  // Result register updates only on completion so partial results never reach Rz.
  always_ff @(posedge clock) begin
    if (reset) begin
      Rz <= '0;
    end else if (finish) begin
      Rz <= acc;
    end
  end

endmodule

// File: tb/tb_shift_rotate_sequencer.sv
// Directed bench for shift_rotate_sequencer with an expected-result queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_shift_rotate_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] Ra;
  logic [31:0] Rb;
  logic [31:0] Rz;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] rz;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  shift_rotate_sequencer dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .Ra    (Ra),
    .Rb    (Rb),
    .Rz    (Rz),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference result built from whole-word shifts rather than single-bit steps.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [4:0] n);
    logic [63:0] d;
    d = {a, a};
    case (o)
      3'd0: return a << n;
      3'd1: return a >> n;
      3'd2: return $unsigned($signed(a) >>> n);
      3'd3: begin d = d << n; return d[63:32]; end
      3'd4: begin d = d >> n; return d[31:0]; end
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Issue one op, optionally inject a stray start at cycle inj, then score the result.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int inj);
    exp_t        e;
    exp_t        got;
    int          cyc;
    bit          seen;
    int          busy_err;
    int          partial;
    logic [31:0] rz_prev;
    logic [31:0] rz_done;

    rz_prev = Rz;
    e.rz    = model(o, a, b[4:0]);
    e.lat   = int'(b[4:0]) + 1;
    exp_q.push_back(e);

    op = o; Ra = a; Rb = b; start = 1'b1;
    cyc = 0; seen = 1'b0; busy_err = 0; partial = 0; rz_done = '0;
    @(negedge clock);
    start = 1'b0;
    while (!seen && cyc <= 40) begin
      if (busy !== 1'b1) busy_err++;
      if (done === 1'b1) begin
        seen    = 1'b1;
        rz_done = Rz;
      end else if (Rz !== rz_prev) begin
        partial++;
      end
      if (cyc == inj) begin
        start = 1'b1; Ra = ~a; Rb = 32'd7; op = 3'd0;
      end
      if (!seen) begin
        @(negedge clock);
        start = 1'b0;
        cyc++;
      end
    end

    got = exp_q.pop_front();
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    chk({tag, ".latency"}, 32'(cyc), 32'(got.lat));
    chk({tag, ".rz"}, rz_done, got.rz);
    chk({tag, ".busy_while_active"}, 32'(busy_err), 32'd0);
    chk({tag, ".no_partial_rz"}, 32'(partial), 32'd0);

    @(negedge clock);
    start = 1'b0;
    chk({tag, ".done_pulse_ends"}, 32'(done), 32'd0);
    chk({tag, ".busy_drops"}, 32'(busy), 32'd0);
    chk({tag, ".rz_held"}, Rz, got.rz);
    @(negedge clock);
    chk({tag, ".stays_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int          dn;
    logic [31:0] ra_r;
    logic [31:0] rb_r;
    logic [2:0]  op_r;

    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; op = '0; Ra = '0; Rb = '0;
    repeat (2) @(negedge clock);
    chk("reset.rz", Rz, 32'h0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op("rol4",     3'd3, 32'h8000_0001, 32'd4,  -1);
    run_op("ror1",     3'd4, 32'h0000_0001, 32'd1,  -1);
    run_op("shl31",    3'd0, 32'h0000_0001, 32'd31, -1);
    run_op("shra31",   3'd2, 32'h8000_0000, 32'd31, -1);
    run_op("shr31",    3'd1, 32'h8000_0000, 32'd31, -1);
    run_op("amt_wrap", 3'd3, 32'h1234_5678, 32'h20, -1);
    run_op("busy_start", 3'd3, 32'hF000_000F, 32'd4, 2);
    run_op("done_start", 3'd4, 32'h0000_00F0, 32'd3, 4);
    run_op("reserved", 3'd5, 32'hCAFE_F00D, 32'd3, -1);
    run_op("shra_pos", 3'd2, 32'h7654_3210, 32'hFFFF_FFE5, -1);

    for (int i = 0; i < 4; i++) begin
      ra_r = $urandom;
      rb_r = $urandom;
      op_r = 3'($urandom_range(0, 4));
      run_op("random", op_r, ra_r, rb_r, -1);
    end

    run_op("pre_reset", 3'd0, 32'h0000_00A5, 32'd2, -1);
    op = 3'd0; Ra = 32'h0000_0003; Rb = 32'd8; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midreset.busy", 32'(busy), 32'd0);
    chk("midreset.done", 32'(done), 32'd0);
    chk("midreset.rz", Rz, 32'h0);
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (done === 1'b1) dn++;
    end
    chk("midreset.no_done", 32'(dn), 32'd0);
    chk("midreset.rz_still_zero", Rz, 32'h0);
    run_op("after_reset", 3'd0, 32'h0000_0003, 32'd8, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
